// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word loads and stores, sign/zero-extended sub-word
// loads, and two-cycle read-modify-write sub-word stores with address exceptions.
module load_store_unit #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic [31:0] dm_rd,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        adel,
  output logic        ades
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] pc_r;
  logic [31:0] merge_r;
  logic        mis_s;
  logic        load_s;
  logic        sub_store_s;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [31:0] addr);
    logic mis;
    case (op)
      OP_LW, OP_SW:         mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = addr[0];
      default:              mis = 1'b0;
    endcase
    return mis || (addr >= DM_BYTES);
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    logic ld;
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: ld = 1'b1;
      default:                             ld = 1'b0;
    endcase
    return ld;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    case (op)
      OP_LH:   res = {{16{half_v[15]}}, half_v};
      OP_LHU:  res = {16'h0000, half_v};
      OP_LB:   res = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res = {24'h000000, byte_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of the current memory word with store data.
  function automatic logic [31:0] merge_store(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] word, input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    if (op == OP_SH) begin
      if (lo[1]) res[31:16] = wdata[15:0];
      else       res[15:0]  = wdata[15:0];
    end else begin
      case (lo)
        2'd0:    res[7:0]   = wdata[7:0];
        2'd1:    res[15:8]  = wdata[7:0];
        2'd2:    res[23:16] = wdata[7:0];
        2'd3:    res[31:24] = wdata[7:0];
        default: res        = word;
      endcase
    end
    return res;
  endfunction

  assign mis_s       = is_misaligned(req_op, req_addr);
  assign load_s      = is_load(req_op);
  assign sub_store_s = (req_op == OP_SH) || (req_op == OP_SB);

  // Memory-side drive: request path in IDLE, latched merge write in WRITE.
  always_comb begin
    dm_addr  = {req_addr[31:2], 2'b00};
    dm_pc    = req_pc;
    dm_wdata = req_wdata;
    dm_we    = 1'b0;
    stall    = 1'b0;
    if (reset) begin
      dm_we = 1'b0;
      stall = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && !mis_s) begin
            dm_we = (req_op == OP_SW);
            stall = sub_store_s;
          end else begin
            dm_we = 1'b0;
            stall = 1'b0;
          end
        end
        WRITE: begin
          dm_addr  = addr_r;
          dm_pc    = pc_r;
          dm_wdata = merge_r;
          dm_we    = 1'b1;
        end
        default: begin
          dm_we = 1'b0;
          stall = 1'b0;
        end
      endcase
    end
  end

  // FSM with registered load result, exception pulses and read-modify-write latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ld_valid <= 1'b0;
      ld_data  <= 32'h0000_0000;
      adel     <= 1'b0;
      ades     <= 1'b0;
      addr_r   <= 32'h0000_0000;
      pc_r     <= 32'h0000_0000;
      merge_r  <= 32'h0000_0000;
    end else begin
      ld_valid <= 1'b0;
      adel     <= 1'b0;
      ades     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (mis_s) begin
              adel <= load_s;
              ades <= !load_s;
            end else if (load_s) begin
              ld_data  <= load_extend(req_op, req_addr[1:0], dm_rd);
              ld_valid <= 1'b1;
            end else if (sub_store_s) begin
              merge_r <= merge_store(req_op, req_addr[1:0], dm_rd, req_wdata);
              addr_r  <= {req_addr[31:2], 2'b00};
              pc_r    <= req_pc;
              state_r <= WRITE;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        // The held copy of the stalled request is ignored here.
        WRITE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// against an arithmetic memory/extension model.
module tb_load_store_unit;
  localparam int DM_WORDS = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [31:0] dm_rd;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        adel;
  logic        ades;

  logic [31:0] mem     [0:DM_WORDS-1];
  logic [31:0] ref_mem [0:DM_WORDS-1];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .dm_rd(dm_rd),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .adel(adel), .ades(ades)
  );

  assign dm_rd = (dm_addr[31:2] < DM_WORDS) ? mem[dm_addr[31:2]] : 32'h0;

  always @(posedge clk) begin
    if (dm_we && (dm_addr[31:2] < DM_WORDS)) mem[dm_addr[31:2]] <= dm_wdata;
  end

  function automatic logic model_mis(input logic [2:0] op, input logic [31:0] addr);
    if (addr >= 32'(4 * DM_WORDS)) return 1'b1;
    if ((op == 3'd0 || op == 3'd5) && (addr % 4) != 0) return 1'b1;
    if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && (addr % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] w, h, b;
    w = ref_mem[addr / 4];
    h = (w >> (16 * ((addr / 2) % 2))) & 32'h0000FFFF;
    b = (w >> (8 * (addr % 4))) & 32'h000000FF;
    case (op)
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    if (op == 3'd7) begin
      sh = 8 * int'(addr % 4);
      mask = 32'h000000FF << sh;
    end else begin
      sh = 16 * int'((addr / 2) % 2);
      mask = 32'h0000FFFF << sh;
    end
    return (ref_mem[addr / 4] & ~mask) | ((wdata << sh) & mask);
  endfunction

  // One complete transaction (including the WRITE cycle of a sub-word store).
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc);
    logic mis, is_ld, is_sub;
    logic [31:0] exp_ld, exp_merge;
    mis = model_mis(op, addr);
    is_ld = (op <= 3'd4);
    is_sub = (op == 3'd6 || op == 3'd7);
    exp_ld = (!mis && is_ld) ? model_load(op, addr) : 32'h0;
    exp_merge = (!mis && is_sub) ? model_merge(op, addr, wdata) : 32'h0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
    #1;
    checks++;
    if (dm_addr !== {addr[31:2], 2'b00}) begin failures++;
      $display("FAIL idle_dm_addr op=%0d addr=%h got %h expected %h", op, addr, dm_addr, {addr[31:2], 2'b00}); end
    checks++;
    if (dm_pc !== pc) begin failures++;
      $display("FAIL idle_dm_pc got %h expected %h", dm_pc, pc); end
    checks++;
    if (stall !== (!mis && is_sub)) begin failures++;
      $display("FAIL stall op=%0d addr=%h got %b expected %b", op, addr, stall, !mis && is_sub); end
    checks++;
    if (dm_we !== (!mis && op == 3'd5)) begin failures++;
      $display("FAIL idle_dm_we op=%0d addr=%h got %b expected %b", op, addr, dm_we, !mis && op == 3'd5); end
    if (!mis && op == 3'd5) begin
      checks++;
      if (dm_wdata !== wdata) begin failures++;
        $display("FAIL sw_wdata got %h expected %h", dm_wdata, wdata); end
    end
    @(posedge clk);
    if (!mis && op == 3'd5) ref_mem[addr / 4] = wdata;
    #1;
    checks++;
    if (ld_valid !== (!mis && is_ld)) begin failures++;
      $display("FAIL ld_valid op=%0d addr=%h got %b expected %b", op, addr, ld_valid, !mis && is_ld); end
    checks++;
    if (adel !== (mis && is_ld)) begin failures++;
      $display("FAIL adel op=%0d addr=%h got %b expected %b", op, addr, adel, mis && is_ld); end
    checks++;
    if (ades !== (mis && !is_ld)) begin failures++;
      $display("FAIL ades op=%0d addr=%h got %b expected %b", op, addr, ades, mis && !is_ld); end
    if (!mis && is_ld) begin
      checks++;
      if (ld_data !== exp_ld) begin failures++;
        $display("FAIL ld_data op=%0d addr=%h got %h expected %h", op, addr, ld_data, exp_ld); end
    end
    if (!mis && is_sub) begin
      #1;
      checks++;
      if (dm_we !== 1'b1 || stall !== 1'b0) begin failures++;
        $display("FAIL write_ctl we=%b stall=%b expected we=1 stall=0", dm_we, stall); end
      checks++;
      if (dm_addr !== {addr[31:2], 2'b00} || dm_pc !== pc) begin failures++;
        $display("FAIL write_addr got %h/%h expected %h/%h", dm_addr, dm_pc, {addr[31:2], 2'b00}, pc); end
      checks++;
      if (dm_wdata !== exp_merge) begin failures++;
        $display("FAIL merge_wdata op=%0d addr=%h got %h expected %h", op, addr, dm_wdata, exp_merge); end
      @(posedge clk);
      ref_mem[addr / 4] = exp_merge;
      #1;
      checks++;
      if (ld_valid !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) begin failures++;
        $display("FAIL after_write_pulses got %b%b%b expected 000", ld_valid, adel, ades); end
    end
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_op = 3'($urandom_range(0, 7)); req_addr = $urandom;
    #1;
    checks++;
    if (dm_we !== 1'b0 || stall !== 1'b0) begin failures++;
      $display("FAIL idle_ctl we=%b stall=%b expected 0 0", dm_we, stall); end
    @(posedge clk); #1;
    checks++;
    if (ld_valid !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) begin failures++;
      $display("FAIL idle_pulses got %b%b%b expected 000", ld_valid, adel, ades); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h10; req_wdata = 32'hCAFE0000; req_pc = 32'h100;
    #1;
    checks++;
    if (dm_we !== 1'b0 || stall !== 1'b0) begin failures++;
      $display("FAIL reset_sw_ctl we=%b stall=%b expected 0 0", dm_we, stall); end
    @(posedge clk); req_op = 3'd7; #1;
    checks++;
    if (dm_we !== 1'b0 || stall !== 1'b0) begin failures++;
      $display("FAIL reset_sb_ctl we=%b stall=%b expected 0 0", dm_we, stall); end
    @(posedge clk); #1;
    checks++;
    if (ld_valid !== 1'b0 || adel !== 1'b0 || ades !== 1'b0 || ld_data !== 32'h0) begin failures++;
      $display("FAIL reset_regs got %b%b%b %h expected 000 00000000", ld_valid, adel, ades, ld_data); end
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_word_store_byte_load();
    run_op(3'd5, 32'h10, 32'h11223344, 32'h200);
    run_op(3'd4, 32'h13, 32'h0, 32'h204);
    checks++;
    if (ld_data !== 32'h00000011 || ld_valid !== 1'b1) begin failures++;
      $display("FAIL lbu_0x13 got %h v=%b expected 00000011 v=1", ld_data, ld_valid); end
  endtask

  task automatic test_byte_rmw();
    run_op(3'd7, 32'h11, 32'hFFFFFFA5, 32'h208);
    checks++;
    if (mem[4] !== 32'h1122A544) begin failures++;
      $display("FAIL sb_0x11_word got %h expected 1122a544", mem[4]); end
  endtask

  task automatic test_extension();
    run_op(3'd5, 32'h20, 32'h8000FFFF, 32'h300);
    run_op(3'd1, 32'h20, 32'h0, 32'h304);
    checks++;
    if (ld_data !== 32'hFFFFFFFF) begin failures++;
      $display("FAIL lh_0x20 got %h expected ffffffff", ld_data); end
    run_op(3'd2, 32'h22, 32'h0, 32'h308);
    checks++;
    if (ld_data !== 32'h00008000) begin failures++;
      $display("FAIL lhu_0x22 got %h expected 00008000", ld_data); end
    run_op(3'd3, 32'h23, 32'h0, 32'h30C);
    checks++;
    if (ld_data !== 32'hFFFFFF80) begin failures++;
      $display("FAIL lb_0x23 got %h expected ffffff80", ld_data); end
  endtask

  task automatic test_address_errors();
    run_op(3'd0, 32'h6, 32'h0, 32'h400);
    run_op(3'd6, 32'h3, 32'h1234, 32'h404);
    run_op(3'd5, 32'h3000, 32'h5555, 32'h408);
    checks++;
    if (mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1]) begin failures++;
      $display("FAIL misaligned_no_write got %h %h expected %h %h", mem[0], mem[1], ref_mem[0], ref_mem[1]); end
  endtask

  task automatic test_reset_in_write();
    run_op(3'd5, 32'h40, 32'hDEADBEEF, 32'h500);
    run_op(3'd0, 32'h40, 32'h0, 32'h504);
    req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h40; req_wdata = 32'h0000AAAA; req_pc = 32'h508;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++;
      $display("FAIL sh_0x40_stall got %b expected 1", stall); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (dm_we !== 1'b0) begin failures++;
      $display("FAIL reset_in_write_we got %b expected 0", dm_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (mem[16] !== 32'hDEADBEEF) begin failures++;
      $display("FAIL abort_word_0x40 got %h expected deadbeef", mem[16]); end
    checks++;
    if (ld_data !== 32'h0 || ld_valid !== 1'b0) begin failures++;
      $display("FAIL reset_ld_data got %h v=%b expected 00000000 v=0", ld_data, ld_valid); end
    run_op(3'd0, 32'h40, 32'h0, 32'h50C);
  endtask

  task automatic test_back_to_back();
    logic [31:0] merged;
    run_op(3'd7, 32'h50, $urandom, 32'h600);
    merged = ref_mem[20];
    run_op(3'd0, 32'h50, 32'h0, 32'h604);
    checks++;
    if (ld_data !== merged || ld_data !== mem[20]) begin failures++;
      $display("FAIL load_after_write got %h expected %h", ld_data, merged); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) addr = 32'h3000 + $urandom_range(0, 255);
      else addr = $urandom_range(0, 255);
      run_op(3'($urandom_range(0, 7)), addr, $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < DM_WORDS; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_word_store_byte_load();
    test_byte_rmw();
    test_extension();
    test_address_errors();
    test_reset_in_write();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
